// File: rtl/deadtime_insertion.sv
// rtl/deadtime_insertion.sv - half-bridge dead-time insertion with shoot-through blocking
// Optional DEADTIME_FAULT_LATCH_EN: a conflict latches into FAULT until fault_clear.
module deadtime_insertion #(
  parameter int bitwidth         = 8,
  parameter int default_deadtime = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                highside_input,
  input  logic                lowside_input,
  input  logic [bitwidth-1:0] deadtime_ticks,
  input  logic                load_enable,
  input  logic                fault_clear,
  output logic                highside_output,
  output logic                lowside_output,
  output logic                deadtime_active_output,
  output logic                fault_output
);

  typedef enum logic [2:0] {
    st_off   = 3'd0,
    st_dead  = 3'd1,
    st_high  = 3'd2,
    st_low   = 3'd3,
    st_fault = 3'd4
  } state_t;

  localparam logic [bitwidth-1:0] reset_ticks = bitwidth'(default_deadtime);
  localparam logic [bitwidth-1:0] one_tick    = bitwidth'(1);

  state_t              state, next_state;
  logic [bitwidth-1:0] counter, next_counter, shadow;
  logic                req_high, req_low, conflict;

  assign req_high = highside_input & ~lowside_input;
  assign req_low  = lowside_input & ~highside_input;
  assign conflict = highside_input & lowside_input;

  // Reset lands in DEAD so a full default gap precedes the first gate after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= st_dead;
      counter <= reset_ticks;
      shadow  <= reset_ticks;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      if (load_enable) shadow <= deadtime_ticks;
    end
  end

`ifndef DEADTIME_FAULT_LATCH_EN
  logic fault_seen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_seen <= 1'b0;
    else          fault_seen <= conflict;
  end
`endif

  always_comb begin
    next_state   = state;
    next_counter = counter;
    if (conflict) begin
`ifdef DEADTIME_FAULT_LATCH_EN
      next_state   = st_fault;
`else
      next_state   = st_dead;
      next_counter = shadow;
`endif
    end else begin
      case (state)
        st_off: begin
          if (req_high)     next_state = st_high;
          else if (req_low) next_state = st_low;
        end
        st_high: begin
          if (!req_high) begin
            next_state   = st_dead;
            next_counter = shadow;
          end
        end
        st_low: begin
          if (!req_low) begin
            next_state   = st_dead;
            next_counter = shadow;
          end
        end
        st_dead: begin
          // Counter saturates at zero; the gap ends one edge after it gets there.
          if (counter != '0)  next_counter = counter - one_tick;
          else if (req_high)  next_state   = st_high;
          else if (req_low)   next_state   = st_low;
          else                next_state   = st_off;
        end
        st_fault: begin
          if (fault_clear) begin
            next_state   = st_dead;
            next_counter = shadow;
          end
        end
        default: begin
          next_state   = st_dead;
          next_counter = shadow;
        end
      endcase
    end
  end

  always_comb begin
    highside_output        = (state == st_high);
    lowside_output         = (state == st_low);
    deadtime_active_output = (state == st_dead) || (state == st_fault);
`ifdef DEADTIME_FAULT_LATCH_EN
    fault_output           = (state == st_fault);
`else
    fault_output           = fault_seen;
`endif
  end

endmodule

// File: tb/tb_deadtime_insertion.sv
// tb/tb_deadtime_insertion.sv - directed vector bench for deadtime_insertion
module tb_deadtime_insertion;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       highside_input = 1'b0;
  logic       lowside_input = 1'b0;
  logic [7:0] deadtime_ticks = 8'd0;
  logic       load_enable = 1'b0;
  logic       fault_clear = 1'b0;
  logic       highside_output, lowside_output, deadtime_active_output, fault_output;

  int compared = 0;
  int mismatched = 0;

  deadtime_insertion #(.bitwidth(8), .default_deadtime(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .highside_input(highside_input),
    .lowside_input(lowside_input),
    .deadtime_ticks(deadtime_ticks),
    .load_enable(load_enable),
    .fault_clear(fault_clear),
    .highside_output(highside_output),
    .lowside_output(lowside_output),
    .deadtime_active_output(deadtime_active_output),
    .fault_output(fault_output)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hi;
    logic       lo;
    logic       ld;
    logic [7:0] ticks;
    logic       exp_hi;
    logic       exp_lo;
    logic       exp_dead;
    logic       exp_fault;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic hi, logic lo, logic ld, logic [7:0] ticks,
                              logic eh, logic el, logic ed, logic ef);
    vec_t v;
    v.hi = hi; v.lo = lo; v.ld = ld; v.ticks = ticks;
    v.exp_hi = eh; v.exp_lo = el; v.exp_dead = ed; v.exp_fault = ef;
    return v;
  endfunction

  task automatic check_int(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(string name, logic eh, logic el, logic ed, logic ef);
    check_int({name, ".hi"},    int'(highside_output),        int'(eh));
    check_int({name, ".lo"},    int'(lowside_output),         int'(el));
    check_int({name, ".dead"},  int'(deadtime_active_output), int'(ed));
    check_int({name, ".fault"}, int'(fault_output),           int'(ef));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts edges with both gates off until one gate rises.
  task automatic measure_gap(string name, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (highside_output || lowside_output) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no gate rose within 400 cycles", name);
    end
  endtask

  initial begin
    int n;

    // Shadow starts at 4; a gap of 5 cycles counting the release cycle.
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 3, 1, 0, 0, 0));
    // High -> low with shadow 3: lowside rises 4 edges after highside falls.
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    // No request: DEAD then OFF, then 1-cycle latency into HIGH.
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    // Load 0 on the DEAD-entry edge: this gap still uses the old shadow of 3.
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    // Shadow 0: exactly one cycle with both gates off.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));

    #1 reset_n = 1'b0;
    highside_input = 1'b1;
    #1 check_outs("reset", 0, 0, 1, 0);
    step();
    step();
    #3 reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      highside_input = vq[i].hi;
      lowside_input  = vq[i].lo;
      load_enable    = vq[i].ld;
      deadtime_ticks = vq[i].ticks;
      step();
      check_outs($sformatf("vec%0d", i), vq[i].exp_hi, vq[i].exp_lo, vq[i].exp_dead, vq[i].exp_fault);
    end
    load_enable = 1'b0;

    // Conflict while in LOW, shadow 3.
    load_enable = 1'b1; deadtime_ticks = 8'd3;
    step();
    load_enable = 1'b0;
    check_outs("pre_conflict", 0, 1, 0, 0);
    highside_input = 1'b1; lowside_input = 1'b1;
    step(); check_outs("conflict1", 0, 0, 1, 1);
    step(); check_outs("conflict2", 0, 0, 1, 1);
    highside_input = 1'b0;
`ifdef DEADTIME_FAULT_LATCH_EN
    for (int i = 0; i < 3; i++) begin
      step(); check_outs($sformatf("fault_hold%0d", i), 0, 0, 1, 1);
    end
    fault_clear = 1'b1;
    step(); check_outs("fault_clear", 0, 0, 1, 0);
    fault_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_outs($sformatf("post_fault%0d", i), 0, 0, 1, 0);
    end
    step(); check_outs("post_fault_low", 0, 1, 0, 0);
`else
    for (int i = 0; i < 3; i++) begin
      step(); check_outs($sformatf("post_conflict%0d", i), 0, 0, 1, 0);
    end
    step(); check_outs("post_conflict_low", 0, 1, 0, 0);
`endif

    // Mid-DEAD load: running gap stays 4, the next one becomes 11.
    lowside_input = 1'b0; highside_input = 1'b1;
    step(); check_outs("mid_dead_entry", 0, 0, 1, 0);
    load_enable = 1'b1; deadtime_ticks = 8'd10;
    step();
    load_enable = 1'b0;
    measure_gap("gap_running", n);
    check_int("gap_running", n + 2, 4);
    check_int("gap_running_hi", int'(highside_output), 1);
    highside_input = 1'b0; lowside_input = 1'b1;
    measure_gap("gap_after_load", n);
    check_int("gap_after_load", n, 11);

    // Maximum shadow: 256-cycle gap, no wrap.
    load_enable = 1'b1; deadtime_ticks = 8'd255;
    step();
    load_enable = 1'b0;
    lowside_input = 1'b0; highside_input = 1'b1;
    measure_gap("gap_max", n);
    check_int("gap_max", n, 256);
    check_int("gap_max_hi", int'(highside_output), 1);
    load_enable = 1'b1; deadtime_ticks = 8'd0;
    step();
    load_enable = 1'b0;
    highside_input = 1'b0; lowside_input = 1'b1;
    measure_gap("gap_zero", n);
    check_int("gap_zero", n, 1);

    // Reset in LOW drops the gate with no clock edge; default gap follows.
    #2 reset_n = 1'b0;
    #1 check_outs("async_reset", 0, 0, 1, 0);
    #1 reset_n = 1'b1;
    measure_gap("gap_after_reset", n);
    check_int("gap_after_reset", n + 1, 5);
    check_int("gap_after_reset_lo", int'(lowside_output), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
